// File: rtl/pad_led_decoder_4_to_12_if.sv
// Bundles the code-producer/LED-driver signals of pad_led_decoder_4_to_12.
//
// Signals:
//   clear      producer -> decoder  synchronous flush of queue and display
//   in_binary  producer -> decoder  4-bit pad code, 0..11 legal
//   in_valid   producer -> decoder  in_binary is valid this cycle
//   in_ready   decoder -> producer  queue can accept a code
//   out_onehot decoder -> LEDs      registered one-hot LED drive
//   busy       decoder -> producer  queue non-empty or display active
//   err        decoder -> producer  one-cycle pulse on an illegal code
//
// Modports: master = code producer, slave = decoder.
interface pad_led_decoder_4_to_12_if;
  logic        clear;
  logic [3:0]  in_binary;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] out_onehot;
  logic        busy;
  logic        err;

  modport master (
    output clear,
    output in_binary,
    output in_valid,
    input  in_ready,
    input  out_onehot,
    input  busy,
    input  err
  );

  modport slave (
    input  clear,
    input  in_binary,
    input  in_valid,
    output in_ready,
    output out_onehot,
    output busy,
    output err
  );
endinterface

// File: rtl/pad_led_decoder_4_to_12.sv
// Pad LED decoder: queues 4-bit pad codes (0..11) in a small FIFO and shows
// each one on a 12-bit one-hot LED bus for HOLD_CYCLES cycles, followed by a
// single dark cycle before the next queued code.
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset; LEDs go dark immediately
//   bus    slave side of pad_led_decoder_4_to_12_if (see that file)
//
// Parameters:
//   HOLD_CYCLES  cycles each LED stays lit (1..255, 8-bit timer)
//   FIFO_DEPTH   queued codes (power of 2, 2..16)
module pad_led_decoder_4_to_12 #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic                         clk,
  input logic                         rst_n,
  pad_led_decoder_4_to_12_if.slave    bus
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [7:0]      HoldLoad = 8'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] CntFull  = CntW'(FIFO_DEPTH);
  localparam logic [CntW-1:0] CntOne   = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne   = PtrW'(1);

  typedef enum logic [1:0] {StIdle, StShow, StGap} state_e;

  // FIFO storage and bookkeeping
  logic [3:0]      r_mem [FIFO_DEPTH];
  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [CntW-1:0] r_count;
  logic [CntW-1:0] w_count_d;

  // Display FSM state
  state_e          r_state;
  state_e          w_state_d;
  logic [7:0]      r_timer;
  logic [7:0]      w_timer_d;
  logic [11:0]     r_onehot;
  logic [11:0]     w_onehot_d;
  logic            r_err;

  logic            w_legal;
  logic            w_full;
  logic            w_empty;
  logic            w_push;
  logic            w_pop;
  logic [3:0]      w_head;

  assign w_legal = (bus.in_binary <= 4'd11);
  assign w_full  = (r_count == CntFull);
  assign w_empty = (r_count == '0);
  assign w_head  = r_mem[r_rd_ptr];

  // Full blocks pushes even if a pop happens this cycle; clear drops the offer.
  assign w_push = bus.in_valid & ~w_full & w_legal & ~bus.clear;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  // Storage is not reset: entries are only read once count says they are valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= bus.in_binary;
    end
  end

  always_comb begin
    w_count_d = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_d = r_count + CntOne;
      2'b01:   w_count_d = r_count - CntOne;
      default: w_count_d = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (bus.clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Pointers wrap naturally because FIFO_DEPTH is a power of 2.
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      r_count <= w_count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Display FSM: next-state / next-output
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_d  = r_state;
    w_timer_d  = r_timer;
    w_onehot_d = r_onehot;
    w_pop      = 1'b0;

    if (bus.clear) begin
      w_state_d  = StIdle;
      w_timer_d  = '0;
      w_onehot_d = '0;
    end else begin
      unique case (r_state)
        // IDLE and GAP both launch the next queued code; the GAP cycle itself
        // is the one dark cycle between back-to-back codes.
        StIdle, StGap: begin
          if (!w_empty) begin
            w_pop      = 1'b1;
            w_onehot_d = 12'd1 << w_head;
            w_timer_d  = HoldLoad;
            w_state_d  = StShow;
          end else begin
            w_onehot_d = '0;
            w_state_d  = StIdle;
          end
        end
        // Timer is loaded with HOLD_CYCLES-1, so the LED is lit for the load
        // cycle plus HOLD_CYCLES-1 countdown cycles.
        StShow: begin
          if (r_timer != '0) begin
            w_timer_d = r_timer - 8'd1;
          end else begin
            w_onehot_d = '0;
            w_state_d  = StGap;
          end
        end
        default: begin
          w_state_d  = StIdle;
          w_timer_d  = '0;
          w_onehot_d = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Display FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_timer  <= '0;
      r_onehot <= '0;
    end else begin
      r_state  <= w_state_d;
      r_timer  <= w_timer_d;
      r_onehot <= w_onehot_d;
    end
  end

  // Illegal-code pulse fires regardless of ready or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= bus.in_valid & ~w_legal;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.in_ready   = ~w_full;
  assign bus.out_onehot = r_onehot;
  assign bus.err        = r_err;
  assign bus.busy       = (r_state != StIdle) | ~w_empty;

endmodule
